// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - sequential restoring divider for DIV/DIVU, fixed 34-edge latency
module alu_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] a_q;     // raw dividend, kept for the divide-by-zero remainder
  logic [WIDTH-1:0] b_q;     // raw divisor, replaced by its magnitude in PREP
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             sgn, sa, sb;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_step, rem_step;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (req_valid) state_nxt = S_PREP;
        S_PREP:  state_nxt = S_ITER;
        S_ITER:  if (cnt == 5'd31) state_nxt = S_FIX;
        S_FIX:   state_nxt = S_DONE;
        S_DONE:  if (out_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // One restoring step: shift the next dividend bit into the remainder and try to subtract.
  always_comb begin
    trial = {rem, quo[WIDTH-1]} - {1'b0, b_q};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = {rem[WIDTH-2:0], quo[WIDTH-1]};
      quo_step = {quo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
      quo <= '0;
      rem <= '0;
      sgn <= 1'b0;
      sa  <= 1'b0;
      sb  <= 1'b0;
      lo  <= '0;
      hi  <= '0;
    end else if (!flush) begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a_q <= req_a;
            b_q <= req_b;
            sgn <= req_signed;
          end
        end
        S_PREP: begin
          sa  <= sgn & a_q[WIDTH-1];
          sb  <= sgn & b_q[WIDTH-1];
          quo <= (sgn & a_q[WIDTH-1]) ? -a_q : a_q;
          b_q <= (sgn & b_q[WIDTH-1]) ? -b_q : b_q;
          rem <= '0;
          cnt <= '0;
        end
        S_ITER: begin
          quo <= quo_step;
          rem <= rem_step;
          cnt <= cnt + 5'd1;
        end
        S_FIX: begin
          // A zero divisor yields all-ones quotient and the untouched dividend.
          if (b_q == '0) begin
            lo <= '1;
            hi <= a_q;
          end else begin
            lo <= (sa ^ sb) ? -quo : quo;
            hi <= sa ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// tb/tb_alu_div_seq.sv - directed self-checking bench for alu_div_seq
module tb_alu_div_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_signed;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] lo;
  logic [31:0] hi;

  int compared = 0;
  int mismatched = 0;

  alu_div_seq #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_signed(req_signed), .req_a(req_a), .req_b(req_b), .flush(flush),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .lo(lo), .hi(hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for out_valid, check latency and result; leaves the block in DONE.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    int n;
    req_valid  = 1'b1;
    req_signed = sgn;
    req_a      = a;
    req_b      = b;
    tick();
    req_valid = 1'b0;
    check({tag, " busy@E0"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, 34);
    check({tag, " lo"}, lo, exp_lo);
    check({tag, " hi"}, hi, exp_hi);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " idle after consume"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int seen_valid;
    resetn = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_a = '0; req_b = '0;
    flush = 1'b0; out_ready = 1'b0;
    #2;
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset hi", hi, 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    check("divu 100/7 busy in DONE", {31'd0, busy}, 32'd1);
    consume("divu 100/7");

    run_div("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    consume("div -7/2");
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    consume("div 7/-2");
    run_div("div ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
    consume("div ovf");
    run_div("divu big", 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF);
    consume("divu big");
    run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5);
    consume("divu 5/0");
    run_div("div -5/0", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB);

    // Hold off the consumer, then release it with a new request already waiting.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold out_valid", {31'd0, out_valid}, 32'd1);
      check("hold lo", lo, 32'hFFFFFFFF);
      check("hold hi", hi, 32'hFFFFFFFB);
    end
    out_ready = 1'b1; req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd100; req_b = 32'd7;
    tick();
    out_ready = 1'b0;
    check("exit DONE req_ready", {31'd0, req_ready}, 32'd1);
    check("exit DONE busy", {31'd0, busy}, 32'd0);
    tick();
    req_valid = 1'b0;
    check("accept next edge", {31'd0, busy}, 32'd1);
    while (!out_valid && compared < 100000) tick();
    check("back-to-back lo", lo, 32'd14);
    check("back-to-back hi", hi, 32'd2);
    consume("back-to-back");

    // Flush at E10 of a 1000/3 request; previous 100/7 result must survive.
    req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd1000; req_b = 32'd3;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush idle", {31'd0, busy}, 32'd0);
    check("flush req_ready", {31'd0, req_ready}, 32'd1);
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen_valid = 1;
    end
    check("flush no out_valid", seen_valid, 0);
    check("flush lo kept", lo, 32'd14);
    check("flush hi kept", hi, 32'd2);

    flush = 1'b1; req_valid = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check("flush blocks accept", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of ITER.
    req_valid = 1'b1; req_a = 32'd1000; req_b = 32'd3;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    #1 resetn = 1'b0;
    #1;
    check("async rst busy", {31'd0, busy}, 32'd0);
    check("async rst req_ready", {31'd0, req_ready}, 32'd1);
    check("async rst out_valid", {31'd0, out_valid}, 32'd0);
    check("async rst lo", lo, 32'd0);
    check("async rst hi", hi, 32'd0);
    resetn = 1'b1;
    #1;
    run_div("post-reset 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    consume("post-reset 100/7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
